// File: rtl/led_pkg.sv
// Shared types and helpers for the LED frame sequencer and its pixel store.
package led_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        LATCH
    } seq_state_t;

    typedef logic [23:0] pixel_t;

    localparam int DEFAULT_LATCH_CYCLES = 2000;

    // Host colours arrive as {R,G,B}; WS2812 parts expect G first on the wire.
    function automatic pixel_t rgb_to_grb(input pixel_t rgb);
        return {rgb[15:8], rgb[23:16], rgb[7:0]};
    endfunction

endpackage

// File: rtl/led_frame_sequencer_pixel_ram.sv
// One frame of pixel colours: synchronous write, registered read, read-before-write.
module pixel_ram
    import led_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int ADDR_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  pixel_t            i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output pixel_t            o_rd_data
);

    pixel_t r_mem [NUM_LEDS];
    pixel_t r_rd_data;
    logic   w_wr_ok;

    // Addresses past the last pixel are representable when NUM_LEDS is not a power of two.
    assign w_wr_ok = i_wr_en && (int'(i_wr_addr) < NUM_LEDS);

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/led_frame_sequencer.sv
// Feeds a stored frame pixel by pixel to send_bytes, then holds the line for the latch gap.
module led_frame_sequencer
    import led_pkg::*;
#(
    parameter int NUM_LEDS     = 8,
    parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
    localparam int ADDR_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    input  logic              frame_start,
    input  logic              tx_done,
    output logic [23:0]       pixel_data,
    output logic              tx_hold,
    output logic              busy,
    output logic              frame_done
);

    localparam int                CNT_W    = $clog2(LATCH_CYCLES);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LATCH_CYCLES - 1);

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    logic [ADDR_W-1:0] r_idx;
    logic [CNT_W-1:0]  r_lcnt;
    pixel_t            r_pixel_data;
    logic              r_tx_hold;
    logic              r_busy;
    logic              r_frame_done;
    logic              r_send_first;

    logic              w_start;
    logic              w_pix_done;
    logic              w_last_pix;
    logic              w_latch_end;
    logic              w_tx_hold_nxt;
    logic              w_busy_nxt;
    logic              w_frame_done_nxt;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;
    pixel_t            w_rd_data;

    pixel_ram #(
        .NUM_LEDS (NUM_LEDS),
        .ADDR_W   (ADDR_W)
    ) u_pixel_ram (
        .clk       (clk),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    // frame_done is high in the first IDLE cycle; a start seen then is dropped.
    assign w_start     = (r_state == IDLE) && frame_start && !r_frame_done;
    // send_bytes is still coming out of reset in the first SEND cycle, so its done is stale.
    assign w_pix_done  = (r_state == SEND) && tx_done && !r_send_first;
    assign w_last_pix  = (r_idx == LAST_IDX);
    assign w_latch_end = (r_state == LATCH) && (r_lcnt == LAST_CNT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_tx_hold    <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_tx_hold    <= w_tx_hold_nxt;
            r_busy       <= w_busy_nxt;
            r_frame_done <= w_frame_done_nxt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                w_next_state = SEND;
            end
            SEND: begin
                if (w_pix_done) begin
                    w_next_state = w_last_pix ? LATCH : FETCH;
                end
            end
            LATCH: begin
                if (w_latch_end) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_comb begin
        w_tx_hold_nxt    = (w_next_state != SEND);
        w_busy_nxt       = (w_next_state != IDLE);
        w_frame_done_nxt = w_latch_end;
        w_rd_en          = w_start || (w_pix_done && !w_last_pix);
        w_rd_addr        = (r_state == IDLE) ? '0 : r_idx + ADDR_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx        <= '0;
            r_lcnt       <= '0;
            r_pixel_data <= '0;
            r_send_first <= 1'b0;
        end else begin
            if (w_start) begin
                r_idx <= '0;
            end else if (w_pix_done && !w_last_pix) begin
                r_idx <= r_idx + ADDR_W'(1);
            end
            r_lcnt <= (r_state == LATCH && !w_latch_end) ? r_lcnt + CNT_W'(1) : '0;
            if (r_state == FETCH) begin
                r_pixel_data <= rgb_to_grb(w_rd_data);
            end
            r_send_first <= (r_state == FETCH);
        end
    end

    assign pixel_data = r_pixel_data;
    assign tx_hold    = r_tx_hold;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
